// File: rtl/chip_cmd_seq.sv
// chip_cmd_seq: turns one command (write or read) from chip_control into a serial
// frame {op, addr, data} on chip_csn/chip_sclk/chip_mosi, MSB first, and returns
// read data captured from chip_miso.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high; cmd_ready is high only in IDLE and rsp_valid only in RESP; the sender keeps
// payload stable while valid is high and not yet accepted.
// Optional feature: define CHIP_CMD_SEQ_PARITY_EN to append an even-parity bit to
// every frame and check the parity bit returned after read data (rsp_err).
module chip_cmd_seq #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              chip_csn,
    output logic              chip_sclk,
    output logic              chip_mosi,
    input  logic              chip_miso,
    output logic [2:0]        state_dbg
);

`ifdef CHIP_CMD_SEQ_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int N       = 1 + ADDR_W + DATA_W + PAR_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(N);
    localparam int DATA_LO = 1 + ADDR_W;      // index of first data bit in the frame
    localparam int DATA_HI = ADDR_W + DATA_W; // index of last data bit in the frame

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              sclk_q;
    logic              op_q;
    logic [N-1:0]      frame_sr;
    logic [N-1:0]      frame_new;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_sr;
    logic              div_end;
    logic              last_bit;
    logic              sample_en;
    logic              rx_data_bit;
    logic              rsp_load;

    assign div_end     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit    = (bit_cnt == BIT_W'(N - 1));
    // chip_miso is taken on the edge that raises chip_sclk
    assign sample_en   = (state == SHIFT) && !sclk_q && div_end;
    assign rx_data_bit = op_q && (bit_cnt >= BIT_W'(DATA_LO)) && (bit_cnt <= BIT_W'(DATA_HI));
    assign rsp_load    = (state == HOLD) && div_end && op_q;

    // reads send zeros in the data field so chip_mosi stays low while the chip talks
    assign tx_data = cmd_op ? '0 : cmd_data;
`ifdef CHIP_CMD_SEQ_PARITY_EN
    assign frame_new = {cmd_op, cmd_addr, tx_data, ^{cmd_op, cmd_addr, tx_data}};
`else
    assign frame_new = {cmd_op, cmd_addr, tx_data};
`endif

    // state register; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   if (div_end) state_nxt = SHIFT;
            SHIFT:   if (sclk_q && div_end && last_bit) state_nxt = HOLD;
            HOLD:    if (div_end) state_nxt = op_q ? RESP : IDLE;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state; csn low spans SETUP..HOLD
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        chip_csn  = 1'b1;
        chip_mosi = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            SETUP, SHIFT: begin
                chip_csn  = 1'b0;
                chip_mosi = frame_sr[N-1];
            end
            HOLD:    chip_csn  = 1'b0;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign chip_sclk = sclk_q;
    assign state_dbg = state;

    // divider, bit counter, sclk phase and transmit shifter; next bit shifts out as sclk falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            op_q     <= 1'b0;
            frame_sr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b0;
                    if (cmd_valid) begin
                        frame_sr <= frame_new;
                        op_q     <= cmd_op;
                    end
                end
                SETUP, HOLD: div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk_q  <= !sclk_q;
                        if (sclk_q && !last_bit) begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            frame_sr <= {frame_sr[N-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    // receive shifter and response register; response only loads on a completed read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr    <= '0;
            rsp_data <= '0;
        end else begin
            if (sample_en && rx_data_bit) rx_sr <= {rx_sr[DATA_W-2:0], chip_miso};
            if (rsp_load) rsp_data <= rx_sr;
        end
    end

`ifdef CHIP_CMD_SEQ_PARITY_EN
    logic par_rx;
    logic rsp_err_q;

    // trailing parity bit from the chip, checked as even parity over the read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_rx    <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (sample_en && last_bit) par_rx <= chip_miso;
            if (rsp_load) rsp_err_q <= ^{rx_sr, par_rx};
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_chip_cmd_seq.sv
// Bench for chip_cmd_seq: table of directed commands on a CLK_DIV=4 instance plus
// hand sequences for back-pressure, mid-frame reset and a CLK_DIV=1 instance.
module tb_chip_cmd_seq;

  localparam int AW = 10;
  localparam int DW = 8;
`ifdef CHIP_CMD_SEQ_PARITY_EN
  localparam int PW = 1;
  localparam int CSN_LOW = 168;
  localparam int CSN_LOW1 = 42;
  localparam logic PERR = 1'b1;
`else
  localparam int PW = 0;
  localparam int CSN_LOW = 160;
  localparam int CSN_LOW1 = 40;
  localparam logic PERR = 1'b0;
`endif
  localparam int N = 1 + AW + DW + PW;
  localparam int LIM = 1000;

  typedef struct packed {
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] ret;
    logic          flip;
    logic [18:0]   exp_bits;
    logic          exp_par;
    logic [DW-1:0] exp_rsp;
    logic          exp_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (CLK_DIV = 4) ----------------
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_data;
  logic          chip_csn, chip_sclk, chip_mosi, chip_miso;
  logic [2:0]    state_dbg;

  chip_cmd_seq #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .chip_csn(chip_csn), .chip_sclk(chip_sclk), .chip_mosi(chip_mosi),
    .chip_miso(chip_miso), .state_dbg(state_dbg)
  );

  // ---------------- DUT (CLK_DIV = 1) ----------------
  logic          cmd_valid1, cmd_ready1, cmd_op1;
  logic [AW-1:0] cmd_addr1;
  logic [DW-1:0] cmd_data1;
  logic          rsp_valid1, rsp_err1, busy1;
  logic          rsp_ready1 = 1'b1;
  logic [DW-1:0] rsp_data1;
  logic          chip_csn1, chip_sclk1, chip_mosi1, chip_miso1;
  logic [2:0]    state_dbg1;

  chip_cmd_seq #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1),
    .cmd_addr(cmd_addr1), .cmd_data(cmd_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .busy(busy1), .chip_csn(chip_csn1), .chip_sclk(chip_sclk1), .chip_mosi(chip_mosi1),
    .chip_miso(chip_miso1), .state_dbg(state_dbg1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [N-1:0]  got_q[$];   // frames seen on chip_mosi of dut
  logic [DW-1:0] exp_q[$];   // expected read data from dut1
  logic [N-1:0]  ret1_q[$];  // frames the dut1 chip model returns

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_frame(input vec_t v);
`ifdef CHIP_CMD_SEQ_PARITY_EN
    return {v.exp_bits, v.exp_par};
`else
    return v.exp_bits;
`endif
  endfunction

  // bits the chip drives on miso, indexed like the outgoing frame
  function automatic logic [N-1:0] mk_ret(input vec_t v);
    logic [N-1:0] r;
    r = '0;
    r[N-12 -: DW] = v.ret;
`ifdef CHIP_CMD_SEQ_PARITY_EN
    r[0] = (^v.ret) ^ v.flip;
`endif
    return r;
  endfunction

  // ---------------- chip model / monitors for dut ----------------
  logic [N-1:0] miso_frame = '0;
  logic [N-1:0] mosi_log = '0;
  int falls = 0, base = 0, rises = 0, idx;
  int low_run = 0, high_run = 0, last_low = 0, last_gap = 0, ready_bad = 0, rsp_cnt = 0;
  logic prev_rv = 1'b0;

  always @(negedge chip_sclk) falls++;
  always @(negedge chip_csn) base = falls;
  always_comb begin
    idx = falls - base;
    chip_miso = (idx >= 0 && idx < N) ? miso_frame[N-1-idx] : 1'b0;
  end
  always @(posedge chip_sclk) begin
    rises++;
    mosi_log = {mosi_log[N-2:0], chip_mosi};
  end
  always @(posedge chip_csn) got_q.push_back(mosi_log);

  always @(negedge clk) begin
    if (!chip_csn) begin
      if (high_run > 0) last_gap = high_run;
      high_run = 0;
      low_run++;
      if (cmd_ready) ready_bad++;
    end else begin
      if (low_run > 0) last_low = low_run;
      low_run = 0;
      high_run++;
    end
    if (rsp_valid && !prev_rv) rsp_cnt++;
    prev_rv = rsp_valid;
  end

  // ---------------- chip model / monitors for dut1 ----------------
  logic [N-1:0] rf1 = '0;
  int falls1 = 0, base1 = 0, rises1 = 0, idx1;
  int low_run1 = 0, last_low1 = 0, toggle_bad = 0;
  logic [2:0] prev_st1 = 3'd0;
  logic prev_sclk1 = 1'b0;
  logic sb_on = 1'b0;

  always @(negedge chip_sclk1) falls1++;
  always @(posedge chip_sclk1) rises1++;
  always @(negedge chip_csn1) begin
    base1 = falls1;
    if (ret1_q.size() > 0) rf1 = ret1_q.pop_front();
  end
  always_comb begin
    idx1 = falls1 - base1;
    chip_miso1 = (idx1 >= 0 && idx1 < N) ? rf1[N-1-idx1] : 1'b0;
  end

  always @(negedge clk) begin
    if (!chip_csn1) low_run1++;
    else begin
      if (low_run1 > 0) last_low1 = low_run1;
      low_run1 = 0;
    end
    if (state_dbg1 == 3'd2 && prev_st1 == 3'd2 && chip_sclk1 == prev_sclk1) toggle_bad++;
    prev_st1 = state_dbg1;
    prev_sclk1 = chip_sclk1;
    if (sb_on && rsp_valid1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL div1_rsp: unexpected response %0h, required none", rsp_data1);
      end else begin
        check("div1_rsp", rsp_data1, exp_q.pop_front());
        check("div1_err", rsp_err1, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input string nm, input logic op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    t = 0;
    while (!cmd_ready && t < LIM) begin @(negedge clk); t++; end
    check({nm, "_accept"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = '0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy && t < LIM) begin @(negedge clk); t++; end
    check({nm, "_idle"}, busy, 0);
    @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input logic [N-1:0] exp);
    if (got_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no frame required %0h", nm, exp);
    end else begin
      check(nm, got_q.pop_front(), exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int t, rc0, unstable;
    miso_frame = mk_ret(v);
    rc0 = rsp_cnt;
    send_cmd(nm, v.op, v.addr, v.data);
    if (!v.op) begin
      wait_idle(nm);
      check({nm, "_no_rsp"}, rsp_cnt - rc0, 0);
    end else begin
      t = 0;
      while (!rsp_valid && t < LIM) begin @(negedge clk); t++; end
      check({nm, "_rsp_valid"}, rsp_valid, 1);
      check({nm, "_rsp_data"}, rsp_data, v.exp_rsp);
      check({nm, "_rsp_err"}, rsp_err, v.exp_err);
      unstable = 0;
      repeat (5) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== v.exp_rsp || rsp_err !== v.exp_err) unstable++;
      end
      check({nm, "_rsp_hold"}, unstable, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({nm, "_rsp_done"}, {rsp_valid, busy}, 0);
      check({nm, "_rsp_once"}, rsp_cnt - rc0, 1);
    end
    check({nm, "_csn_low"}, last_low, CSN_LOW);
    check_frame({nm, "_mosi"}, exp_frame(v));
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];
  vec_t tmp;

  initial begin
    int t, acc, rc0, r0, rb0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
    cmd_valid1 = 1'b0; cmd_op1 = 1'b0; cmd_addr1 = '0; cmd_data1 = '0;

    //          op    addr     data   ret    flip  frame bits                 par   rsp    err
    vecs[0] = '{1'b0, 10'h155, 8'hA5, 8'h00, 1'b0, 19'b0_0101010101_10100101, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 10'h003, 8'hFF, 8'h3C, 1'b0, 19'b1_0000000011_00000000, 1'b1, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 10'h3FF, 8'hFF, 8'h00, 1'b0, 19'b0_1111111111_11111111, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 10'h200, 8'h00, 8'h81, 1'b0, 19'b1_1000000000_00000000, 1'b0, 8'h81, 1'b0};
    vecs[4] = '{1'b0, 10'h000, 8'h01, 8'h00, 1'b0, 19'b0_0000000000_00000001, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 10'h2AA, 8'h5A, 8'hFF, 1'b0, 19'b1_1010101010_00000000, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{1'b1, 10'h003, 8'h00, 8'h3C, 1'b1, 19'b1_0000000011_00000000, 1'b1, 8'h3C, PERR};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_csn", chip_csn, 1);
    check("rst_sclk", chip_sclk, 0);
    check("rst_mosi", chip_mosi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    got_q.delete();

    // table of single commands
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // cmd_valid held across a write: second command waits for csn high
    rb0 = ready_bad;
    last_gap = -1;
    miso_frame = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 10'h0F0; cmd_data = 8'h3C;
    t = 0;
    while (!cmd_ready && t < LIM) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_addr = 10'h00F; cmd_data = 8'hC3;
    check("hold_busy", cmd_ready, 0);
    t = 0;
    while (!cmd_ready && t < LIM) begin @(negedge clk); t++; end
    check("hold_second_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("hold");
    check("hold_gap", last_gap >= 1, 1);
    check("hold_ready_low", ready_bad - rb0, 0);
`ifdef CHIP_CMD_SEQ_PARITY_EN
    check_frame("hold_frame1", {19'b0_0011110000_00111100, 1'b0});
    check_frame("hold_frame2", {19'b0_0000001111_11000011, 1'b0});
`else
    check_frame("hold_frame1", 19'b0_0011110000_00111100);
    check_frame("hold_frame2", 19'b0_0000001111_11000011);
`endif

    // reset during bit 7 of a read
    miso_frame = mk_ret(vecs[1]);
    rc0 = rsp_cnt;
    send_cmd("abort", 1'b1, 10'h003, 8'h00);
    r0 = rises;
    t = 0;
    while (rises - r0 < 8 && t < LIM) begin @(negedge clk); t++; end
    check("abort_sclk_high", chip_sclk, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_csn", chip_csn, 1);
    check("abort_sclk", chip_sclk, 0);
    check("abort_mosi", chip_mosi, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    repeat (20) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - rc0, 0);
    check("abort_rsp_data", rsp_data, 0);
    check("abort_ready", cmd_ready, 1);
    run_vec(vecs[3], "after_abort");

    // CLK_DIV = 1, back-to-back reads with rsp_ready tied high
    tmp = vecs[1];
    tmp.ret = 8'h5A; ret1_q.push_back(mk_ret(tmp)); exp_q.push_back(8'h5A);
    tmp.ret = 8'hC3; ret1_q.push_back(mk_ret(tmp)); exp_q.push_back(8'hC3);
    tmp.ret = 8'h0F; ret1_q.push_back(mk_ret(tmp)); exp_q.push_back(8'h0F);
    sb_on = 1'b1;
    toggle_bad = 0;
    r0 = rises1;
    @(negedge clk);
    cmd_valid1 = 1'b1; cmd_op1 = 1'b1; cmd_addr1 = 10'h123; cmd_data1 = 8'h00;
    acc = 0;
    t = 0;
    while (acc < 3 && t < LIM) begin
      if (cmd_ready1) acc++;
      @(negedge clk);
      t++;
    end
    cmd_valid1 = 1'b0;
    t = 0;
    while (exp_q.size() > 0 && t < LIM) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check("div1_accepts", acc, 3);
    check("div1_all_rsp", exp_q.size(), 0);
    check("div1_toggle", toggle_bad, 0);
    check("div1_rises", rises1 - r0, 3 * N);
    check("div1_csn_low", last_low1, CSN_LOW1);
    check("div1_idle", busy1, 0);
    check("ready_during_frame", ready_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chip_cmd_seq.md
CHIP_CMD_SEQ -- requirements
Module: chip_cmd_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, Bayesian-array word address width.
REQ-002 SHALL have parameter DATA_W, default 8, array word width.
REQ-003 SHALL have parameter CLK_DIV, default 4, chip_sclk half-period in clk cycles (legal range 1..255).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered by chip_control.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  in  1  0 = write, 1 = read.
REQ-009 cmd_addr  in  ADDR_W  array word address.
REQ-010 cmd_data  in  DATA_W  write data (ignored for reads).
REQ-011 rsp_valid  out  1  read data available.
REQ-012 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_data  out  DATA_W  captured read data.
REQ-014 rsp_err  out  1  read parity error (0 when parity compiled out).
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 chip_csn  out  1  chip select to chip, active low.
REQ-017 chip_sclk  out  1  serial clock to chip, idle low.
REQ-018 chip_mosi  out  1  serial data to chip.
REQ-019 chip_miso  in  1  serial data from chip, already synchronised externally.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD, RESP; cmd_ready = 1 only in IDLE.
REQ-021 On acceptance SHALL latch op/addr/data into frame = {op, addr, data} (N = 1+ADDR_W+DATA_W bits, MSB first), go to SETUP, drive chip_csn low next cycle.
REQ-022 SETUP SHALL hold chip_csn low, chip_sclk low, chip_mosi = frame MSB for CLK_DIV cycles, then enter SHIFT.
REQ-023 SHIFT, per bit: chip_sclk low CLK_DIV cycles with chip_mosi stable, then high CLK_DIV cycles; next bit presented on falling edge.
REQ-024 During read data bits chip_mosi SHALL be 0; chip_miso SHALL be sampled in the clk cycle chip_sclk goes high and shifted into rsp_data MSB first.
REQ-025 After bit N, HOLD SHALL keep chip_csn low, chip_sclk low for CLK_DIV cycles, then raise chip_csn.
REQ-026 Write: HOLD -> IDLE; read: HOLD -> RESP with rsp_valid = 1.
REQ-027 RESP SHALL hold rsp_valid, rsp_data, rsp_err stable until rsp_ready, then -> IDLE; rsp_ready ignored outside RESP.
REQ-028 chip_csn SHALL stay high at least 1 cycle between frames; csn-low time = CLK_DIV*(2N+2) cycles.
REQ-029 Bit counter and divider counter SHALL be sized clog2 of their maxima and never wrap within a frame.
REQ-030 cmd_* inputs SHALL be ignored when cmd_ready = 0; no command queuing.

Reset
REQ-031 rst SHALL force IDLE immediately, including mid-frame: chip_csn = 1, chip_sclk = 0, chip_mosi = 0, cmd_ready = 1 after release, rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0, counters = 0.
REQ-032 An aborted frame SHALL NOT produce a response.

Configuration
REQ-033 With CHIP_CMD_SEQ_PARITY_EN defined, SHALL append one even-parity bit over {op, addr, data-or-zero} (N += 1); for reads, one extra bit SHALL be sampled after data and rsp_err = 1 if it mismatches even parity over read data.
REQ-034 Without CHIP_CMD_SEQ_PARITY_EN, frame SHALL be N bits as REQ-021 and rsp_err SHALL be tied 0.

Verification
REQ-035 Write op=0 addr=0x155 data=0xA5, defaults -> chip_mosi bits 0,0101010101,10100101; csn low exactly 160 cycles; no rsp_valid.
REQ-036 Read addr=0x003, chip model returns 0x3C -> rsp_valid with rsp_data=0x3C, rsp_err=0; held 5 cycles while rsp_ready=0, stable throughout.
REQ-037 cmd_valid held high across a write -> second command accepted only after csn high >= 1 cycle; cmd_ready = 0 whole frame.
REQ-038 rst pulsed at bit 7 of a read -> chip_csn=1, chip_sclk=0 same cycle (async); no rsp_valid afterward; next command completes normally.
REQ-039 CHIP_CMD_SEQ_PARITY_EN defined, read returning 0x3C with parity bit 1 -> rsp_err=1; with parity bit 0 -> rsp_err=0; csn low 168 cycles.
REQ-040 CLK_DIV=1, back-to-back reads with rsp_ready tied 1 -> sclk toggles every cycle, all data correct.
